// File: rtl/stacker_pkg.sv
// Constants and types shared by the stacker's loader, box plotter and VGA top level.
package stacker_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERASE,
    ST_DRAW,
    ST_DONE
  } plot_state_e;

endpackage

// File: rtl/box_scan_counter.sv
// Raster counter over one box: dx runs fastest, dy steps when dx wraps.
module box_scan_counter #(
  parameter int BOX_W = 4,
  parameter int BOX_H = 4,
  localparam int DX_W = (BOX_W > 1) ? $clog2(BOX_W) : 1,
  localparam int DY_W = (BOX_H > 1) ? $clog2(BOX_H) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [DX_W-1:0] dx_o,
  output logic [DY_W-1:0] dy_o,
  output logic            last_o
);

  localparam logic [DX_W-1:0] DX_MAX = DX_W'(BOX_W - 1);
  localparam logic [DY_W-1:0] DY_MAX = DY_W'(BOX_H - 1);
  localparam logic [DX_W-1:0] DX_ONE = DX_W'(1);
  localparam logic [DY_W-1:0] DY_ONE = DY_W'(1);

  logic [DX_W-1:0] dx_q;
  logic [DY_W-1:0] dy_q;
  logic            dx_last;
  logic            dy_last;

  assign dx_last = (dx_q == DX_MAX);
  assign dy_last = (dy_q == DY_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset || clr_i) begin
      dx_q <= '0;
      dy_q <= '0;
    end else if (en_i) begin
      if (dx_last) begin
        dx_q <= '0;
        dy_q <= dy_last ? '0 : dy_q + DY_ONE;
      end else begin
        dx_q <= dx_q + DX_ONE;
      end
    end
  end

  assign dx_o   = dx_q;
  assign dy_o   = dy_q;
  assign last_o = dx_last && dy_last;

endmodule

// File: rtl/box_plotter.sv
// Rasterises one box per request onto the VGA plot port, optionally
// blacking out the previously drawn box first. One pixel per clock.
module box_plotter #(
  parameter int BOX_W    = 4,
  parameter int BOX_H    = 4,
  parameter int SCREEN_W = stacker_pkg::SCREEN_W,
  parameter int SCREEN_H = stacker_pkg::SCREEN_H
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  input  logic       erase_prev,
  output logic       ready,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       done
);

  import stacker_pkg::*;

  localparam int DX_W = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int DY_W = (BOX_H > 1) ? $clog2(BOX_H) : 1;

  plot_state_e state_q;

  logic [7:0] cur_x_q;
  logic [6:0] cur_y_q;
  logic [2:0] cur_col_q;
  logic [7:0] prev_x_q;
  logic [6:0] prev_y_q;
  logic       prev_valid_q;

  logic            accept;
  logic            scanning;
  logic            cnt_clr;
  logic            last;
  logic [DX_W-1:0] dx;
  logic [DY_W-1:0] dy;

  assign accept   = req && (state_q == ST_IDLE);
  assign scanning = (state_q == ST_ERASE) || (state_q == ST_DRAW);
  // Restart the raster on accept and again at the ERASE -> DRAW handover.
  assign cnt_clr  = accept || ((state_q == ST_ERASE) && last);

  box_scan_counter #(
    .BOX_W (BOX_W),
    .BOX_H (BOX_H)
  ) u_scan (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .en_i   (scanning),
    .dx_o   (dx),
    .dy_o   (dy),
    .last_o (last)
  );

  // NOTE: only control state (FSM, prev_valid) is reset; the coordinate and
  // colour latches are always written before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      prev_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            cur_x_q   <= x_in;
            cur_y_q   <= y_in;
            cur_col_q <= colour_in;
            state_q   <= (erase_prev && prev_valid_q) ? ST_ERASE : ST_DRAW;
          end
        end
        ST_ERASE: begin
          if (last) state_q <= ST_DRAW;
        end
        ST_DRAW: begin
          if (last) begin
            prev_x_q     <= cur_x_q;
            prev_y_q     <= cur_y_q;
            prev_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] pix_col;
  logic [8:0] sx;
  logic [7:0] sy;
  logic       in_view;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    base_x  = cur_x_q;
    base_y  = cur_y_q;
    pix_col = cur_col_q;
    if (state_q == ST_ERASE) begin
      base_x  = prev_x_q;
      base_y  = prev_y_q;
      pix_col = COLOUR_BLACK;
    end
  end

  // One spare bit on each sum keeps off-screen pixels from aliasing back on.
  assign sx      = {1'b0, base_x} + 9'(dx);
  assign sy      = {1'b0, base_y} + 8'(dy);
  assign in_view = (sx < 9'(SCREEN_W)) && (sy < 8'(SCREEN_H));

  assign vga_x      = scanning ? sx[7:0] : 8'd0;
  assign vga_y      = scanning ? sy[6:0] : 7'd0;
  assign vga_colour = scanning ? pix_col : COLOUR_BLACK;
  assign plot       = scanning && in_view;
  assign done       = (state_q == ST_DONE);
  assign ready      = (state_q == ST_IDLE);

endmodule

// File: tb/tb_box_plotter.sv
// Directed bench for box_plotter: expected pixels/done are queued at issue,
// and an independent monitor pops and compares on every plot or done cycle.
module tb_box_plotter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [2:0] colour_in = '0;
  logic       erase_prev = 1'b0;
  logic       ready;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       done;

  box_plotter dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .x_in       (x_in),
    .y_in       (y_in),
    .colour_in  (colour_in),
    .erase_prev (erase_prev),
    .ready      (ready),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  plot_cnt = 0;
  int  done_cnt = 0;

  bit         m_prev_valid = 1'b0;
  logic [7:0] m_px = '0;
  logic [6:0] m_py = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Queue the visible pixels of a box in raster order, stopping after 'upto' pixel slots.
  task automatic push_box(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] c,
                          input int upto);
    int k;
    int sx;
    int sy;
    k = 0;
    for (int dy = 0; dy < 4; dy++) begin
      for (int dx = 0; dx < 4; dx++) begin
        sx = int'(bx) + dx;
        sy = int'(by) + dy;
        if (k < upto && sx < 160 && sy < 120)
          exp_q.push_back('{1'b0, sx[7:0], sy[6:0], c});
        k++;
      end
    end
  endtask

  always @(negedge clk) begin
    ev_t a;
    ev_t e;
    if (plot || done) begin
      if (plot) plot_cnt++;
      if (done) done_cnt++;
      a = done ? ev_t'({1'b1, 18'd0}) : ev_t'({1'b0, vga_x, vga_y, vga_colour});
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(a), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check(e.is_done ? "done_event" : "pixel", 32'(a), 32'(e));
      end
    end
  end

  // Issue one request; exp_cyc is the cycle after E0 in which done must show.
  task automatic send(input string name, input logic [7:0] x, input logic [6:0] y,
                      input logic [2:0] c, input logic er, input int exp_cyc,
                      input int exp_plots, input bit busy, input int abort_at);
    int n;
    int done_at;
    int plots0;
    int dones0;
    n = 0;
    done_at = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready_before"}, 32'(ready), 32'd1);

    if (er && m_prev_valid) push_box(m_px, m_py, 3'b000, 16);
    push_box(x, y, c, (abort_at > 0) ? abort_at : 16);
    if (abort_at == 0) exp_q.push_back('{1'b1, 8'd0, 7'd0, 3'd0});

    x_in = x; y_in = y; colour_in = c; erase_prev = er; req = 1'b1;
    plots0 = plot_cnt;
    dones0 = done_cnt;
    @(posedge clk);
    for (int cyc = 1; cyc <= exp_cyc + 1; cyc++) begin
      @(negedge clk);
      if (cyc == 1) req = 1'b0;
      if (busy && cyc == 5) begin req = 1'b1; x_in = 8'd40; end
      if (busy && cyc == 6) begin req = 1'b0; x_in = x; end
      if (done && done_at == 0) done_at = cyc;
      if (abort_at > 0) begin
        if (cyc == abort_at) reset = 1'b0;
        if (cyc == abort_at + 1) begin
          check({name, "_plot_after_reset"}, 32'(plot), 32'd0);
          check({name, "_done_after_reset"}, 32'(done), 32'd0);
          reset = 1'b1;
        end
        if (cyc == abort_at + 2) begin
          check({name, "_ready_after_reset"}, 32'(ready), 32'd1);
          check({name, "_plots"}, 32'(plot_cnt - plots0), 32'(exp_plots));
          check({name, "_no_done"}, 32'(done_cnt - dones0), 32'd0);
          m_prev_valid = 1'b0;
          break;
        end
      end
    end
    if (abort_at == 0) begin
      check({name, "_done_cycle"}, 32'(done_at), 32'(exp_cyc));
      check({name, "_ready_after"}, 32'(ready), 32'd1);
      check({name, "_plots"}, 32'(plot_cnt - plots0), 32'(exp_plots));
      check({name, "_done_count"}, 32'(done_cnt - dones0), 32'd1);
      m_prev_valid = 1'b1;
      m_px = x;
      m_py = y;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_vga_x", 32'(vga_x), 32'd0);
    check("rst_vga_y", 32'(vga_y), 32'd0);
    check("rst_vga_colour", 32'(vga_colour), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    //    name           x       y       col     er    done plots busy abort
    send("first_box",    8'd0,   7'd116, 3'b100, 1'b1, 17, 16, 1'b0, 0);
    send("erase_draw",   8'd4,   7'd116, 3'b010, 1'b1, 33, 32, 1'b0, 0);
    send("corner_clip",  8'd158, 7'd118, 3'b001, 1'b0, 17, 4,  1'b0, 0);
    send("busy_ignore",  8'd20,  7'd30,  3'b011, 1'b1, 33, 20, 1'b1, 0);
    send("abort_draw",   8'd50,  7'd60,  3'b101, 1'b0, 17, 8,  1'b0, 8);
    send("after_abort",  8'd60,  7'd10,  3'b110, 1'b1, 17, 16, 1'b0, 0);
    send("no_erase",     8'd64,  7'd10,  3'b111, 1'b0, 17, 16, 1'b0, 0);
    send("erase_moved",  8'd68,  7'd10,  3'b001, 1'b1, 33, 32, 1'b0, 0);

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/box_plotter.md
# box_plotter

Pixel-rasterising back end for the stacker's moving block. It accepts one box position and colour per request from the position/colour loader and optionally erases the previously drawn box by painting it black. It then writes every pixel of the new box, one pixel per clock, onto the VGA adapter's plot port. It is the consumer end of the x/y/colour interface, sitting between the loader and the 160x120 VGA adapter.

## Interface
- BOX_W, 4, box width in pixels (matches the 4-pixel horizontal step)
- BOX_H, 4, box height in pixels
- SCREEN_W, 160, visible columns; pixels at x >= SCREEN_W are clipped
- SCREEN_H, 120, visible rows; pixels at y >= SCREEN_H are clipped
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-low; clock clk
- req  in  1  request strobe; accepted only on a rising edge of clk where req && ready
- x_in  in  8  box top-left column
- y_in  in  7  box top-left row
- colour_in  in  3  box colour (3'b000 is legal and draws black)
- erase_prev  in  1  sampled with req; 1 = erase the last drawn box before drawing
- ready  out  1  high only in IDLE
- vga_x  out  8  pixel column to adapter
- vga_y  out  7  pixel row to adapter
- vga_colour  out  3  pixel colour to adapter
- plot  out  1  adapter write enable for the current pixel
- done  out  1  one-cycle pulse after the last pixel of a request

## Operation
- States: IDLE, ERASE, DRAW, DONE.
- IDLE: ready=1, plot=0.
  - On accept, latch x_in, y_in, colour_in and erase_prev into cur_x, cur_y, cur_col and er.
  - Clear dx and dy.
  - Go to ERASE if er && prev_valid; otherwise go to DRAW.
- ERASE:
  - Pixel base is prev_x/prev_y; colour is forced to 3'b000.
  - Emits BOX_W*BOX_H pixels.
  - After the last pixel, clear dx/dy and go to DRAW.
- DRAW:
  - Pixel base is cur_x/cur_y; colour is cur_col.
  - Emits BOX_W*BOX_H pixels.
  - After the last pixel: prev_x<=cur_x, prev_y<=cur_y, prev_valid<=1, then go to DONE.
- DONE: done=1 and ready=0 for exactly one cycle, then IDLE.
- Raster order: dx increments fastest, 0..BOX_W-1. dy increments when dx wraps. The last pixel is dx=BOX_W-1, dy=BOX_H-1.
- Pixel address arithmetic:
  - sx = {1'b0,base_x}+dx (9 bits); sy = {1'b0,base_y}+dy (8 bits).
  - vga_x = sx[7:0]; vga_y = sy[6:0].
  - plot = 1 only if sx < SCREEN_W and sy < SCREEN_H.
  - A clipped pixel still consumes its cycle, so the per-phase cycle count is always BOX_W*BOX_H.
- req while ready=0 is ignored. There is no queue, and latched values do not change.
- erase_prev with prev_valid=0 (first box after reset) skips ERASE silently.
- The erase colour is always black, independent of colour_in.

## Timing
- vga_x, vga_y, vga_colour, plot and done are driven only from registers (state, counters, latches). They have no combinational path from req or any other input.
- Accept at edge E0. Pixel k of a phase is presented in the cycle following edge E0+k.
- Draw only: plot cycles follow E0..E15, done follows E16, ready=1 follows E17.
- Erase+draw: 32 pixel cycles follow E0..E31, done follows E32, ready=1 follows E33.
- Reset values:
  - state=IDLE, ready=1.
  - vga_x=0, vga_y=0, vga_colour=0, plot=0, done=0.
  - prev_valid=0, dx=dy=0.
- Reset asserted mid-ERASE or mid-DRAW:
  - plot=0 from the next cycle.
  - prev_* are not updated and prev_valid is cleared.
  - No done pulse is produced.
- back-to-back: req held high through DONE is ignored. The next accept occurs at the first edge with ready=1.

## Structure
- Shared package stacker_pkg holds:
  - SCREEN_W and SCREEN_H;
  - COLOUR_BLACK = 3'b000;
  - the plotter state enum (IDLE, ERASE, DRAW, DONE).
- The loader and the VGA top level import the same constants.
- One sub-module: box_scan_counter.
  - Contains the dx/dy raster counter with clear and enable inputs.
  - Outputs dx, dy and a combinational last flag.
  - Widths are sized from BOX_W/BOX_H.
- The plotter FSM, latches, clip compare and output registers live in box_plotter.

## Test plan
- Reset then req with x=0, y=116, colour=3'b100, erase_prev=1 -> no ERASE (prev_valid=0); 16 plots covering x 0..3, y 116..119, colour 100; done follows E16.
- Then req with x=4, y=116, colour=3'b010, erase_prev=1 -> 16 black plots at x 0..3, y 116..119, then 16 plots colour 010 at x 4..7; done follows E32.
- req with x=158, y=118 -> plot=0 for the pixels at x=160,161 and y=120,121; exactly 4 plots (x 158..159, y 118..119); total cycles still 16.
- req pulsed again at E5 while busy, with x=40 -> ignored; the second box is still drawn at the first request's x; no extra done.
- Reset asserted at pixel 7 of DRAW -> plot=0 next cycle, no done, ready=1.
  - A following req with erase_prev=1 skips ERASE.
- erase_prev=0 with prev_valid=1 -> DRAW only, 16 cycles; prev updated to the new box.
